// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types : shared LC-3b word, write-mask and memory-op types
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam int MEM_DEFAULT_LATENCY = 3;

  typedef enum logic {
    mem_op_read  = 1'b0,
    mem_op_write = 1'b1
  } lc3b_mem_op;

endpackage

`default_nettype wire

// File: rtl/lc3b_mem_responder_ram.sv
// ---------------------------------------------------------------------------
// lc3b_byte_ram : word array with per-byte write enable and registered read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lc3b_byte_ram #(
  parameter int WORDS_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [1:0]            be,
  input  logic [WORDS_LOG2-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  logic [15:0] r_mem [2**WORDS_LOG2];
  logic [15:0] r_rdata;

  // The read register only moves on a read access, so it doubles as the held read result.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (be[0]) r_mem[addr][7:0]  <= wdata[7:0];
        if (be[1]) r_mem[addr][15:8] <= wdata[15:8];
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/lc3b_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3b_mem_responder : slave end of the LC-3b mem_read/mem_write/mem_resp
// handshake with configurable wait states. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY    = MEM_DEFAULT_LATENCY,
  parameter int WORDS_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam bit         c_ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] c_LOAD     = c_ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [WORDS_LOG2-1:0] r_idx;
  lc3b_word              r_wdata;
  lc3b_mem_wmask         r_be;
  lc3b_mem_op            r_op;
  logic                  r_proto_err;
  logic                  r_rd_valid;

  logic                  w_req;
  logic                  w_accept;
  logic                  w_access;
  lc3b_mem_op            w_live_op;
  lc3b_mem_op            w_acc_op;
  logic [WORDS_LOG2-1:0] w_acc_idx;
  lc3b_word              w_acc_wdata;
  lc3b_mem_wmask         w_acc_be;
  lc3b_word              w_ram_rdata;
  logic                  w_unused_addr;

  assign w_req     = mem_read | mem_write;
  assign w_accept  = (r_state == ST_IDLE) && w_req;
  assign w_live_op = mem_write ? mem_op_write : mem_op_read;
  assign w_unused_addr = ^{mem_address[15:WORDS_LOG2+1], mem_address[0]};

  // With zero wait states the access happens on the accepting edge, straight from the live inputs.
  assign w_access    = ((r_state == ST_BUSY) && (r_cnt == 4'd0)) || (c_ZERO_LAT && w_accept);
  assign w_acc_op    = c_ZERO_LAT ? w_live_op : r_op;
  assign w_acc_idx   = c_ZERO_LAT ? mem_address[WORDS_LOG2:1] : r_idx;
  assign w_acc_wdata = c_ZERO_LAT ? mem_wdata : r_wdata;
  assign w_acc_be    = c_ZERO_LAT ? mem_byte_enable : r_be;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_next = c_ZERO_LAT ? ST_RESP : ST_BUSY;
      ST_BUSY: if (r_cnt == 4'd0) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_proto_err <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= c_LOAD;
      end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_accept && mem_read && mem_write) r_proto_err <= 1'b1;
      if (w_access && (w_acc_op == mem_op_read)) r_rd_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= mem_address[WORDS_LOG2:1];
      r_wdata <= mem_wdata;
      r_be    <= mem_byte_enable;
      r_op    <= w_live_op;
    end
  end

  lc3b_byte_ram #(
    .WORDS_LOG2 (WORDS_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (w_access),
    .we    (w_acc_op == mem_op_write),
    .be    (w_acc_be),
    .addr  (w_acc_idx),
    .wdata (w_acc_wdata),
    .rdata (w_ram_rdata)
  );

  // Until the first read after reset the RAM register is stale, so present zero.
  assign mem_rdata = r_rd_valid ? w_ram_rdata : 16'h0000;
  assign mem_resp  = (r_state == ST_RESP);
  assign proto_err = r_proto_err;

endmodule

`default_nettype wire
